// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light front end and controller:
// channel indices, debounce counter width and the 1 ms prescaler divisor.
package traffic_pkg;

  localparam int CH_NN = 0;
  localparam int CH_NS = 1;
  localparam int CH_TH = 2;

  localparam int DB_CNT_W = 8;

  function automatic int ms_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One input channel: two-flop synchronizer followed by a tick-paced debounce
// counter. Q only follows the synced level after DEBOUNCE_MS ticks of disagreement.
module debounce_ch
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic TICK,
  input  logic D,
  output logic Q
);

  logic                d_p0;
  logic                d_p1;
  logic                db;
  logic [DB_CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      d_p0 <= 1'b0;
      d_p1 <= 1'b0;
      db   <= 1'b0;
      cnt  <= '0;
    end else begin
      // synchronizer stages
      d_p0 <= D;
      d_p1 <= d_p0;
      // debounce stage: any return to agreement discards the partial count
      if (d_p1 == db) begin
        cnt <= '0;
      end else if (TICK) begin
        if (cnt == DB_CNT_W'(DEBOUNCE_MS - 1)) begin
          db  <= d_p1;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign Q = db;

endmodule

// File: rtl/input_conditioner.sv
// Sensor/button front end for the traffic controller: 1 ms prescaler, six
// debounced channels, latched pedestrian requests. Stuck-button detection is
// built only when INPUT_CONDITIONER_STUCK_DETECT_EN is defined.
module input_conditioner
  import traffic_pkg::*;
#(
  parameter int CLK_HZ      = 48000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int STUCK_MS    = 10000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SNN,
  input  logic       SNS,
  input  logic       STH,
  input  logic       PNN,
  input  logic       PNS,
  input  logic       PTH,
  input  logic       ACK_NN,
  input  logic       ACK_NS,
  input  logic       ACK_TH,
  output logic       SNN_Q,
  output logic       SNS_Q,
  output logic       STH_Q,
  output logic       REQ_NN,
  output logic       REQ_NS,
  output logic       REQ_TH,
  output logic [2:0] FAULT,
  output logic       TICK_1MS
);

  localparam int MS_DIV = ms_div(CLK_HZ);
  localparam int PW     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PW'(MS_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign TICK_1MS = tick;

  logic [2:0] sens_raw, sens_db, ped_raw, ped_db, ped_db_d, ack, req, rise;

  assign sens_raw[CH_NN] = SNN;
  assign sens_raw[CH_NS] = SNS;
  assign sens_raw[CH_TH] = STH;
  assign ped_raw[CH_NN]  = PNN;
  assign ped_raw[CH_NS]  = PNS;
  assign ped_raw[CH_TH]  = PTH;
  assign ack[CH_NN]      = ACK_NN;
  assign ack[CH_NS]      = ACK_NS;
  assign ack[CH_TH]      = ACK_TH;

  for (genvar i = 0; i < 3; i++) begin : g_ch
    debounce_ch #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_sens (
      .CLK (CLK),
      .RST (RST),
      .TICK(tick),
      .D   (sens_raw[i]),
      .Q   (sens_db[i])
    );
    debounce_ch #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_ped (
      .CLK (CLK),
      .RST (RST),
      .TICK(tick),
      .D   (ped_raw[i]),
      .Q   (ped_db[i])
    );
  end

  assign rise = ped_db & ~ped_db_d;

  logic [2:0] fault, hit;

`ifdef INPUT_CONDITIONER_STUCK_DETECT_EN
  logic [2:0][15:0] ms_cnt;

  always_comb begin
    hit = '0;
    for (int i = 0; i < 3; i++) begin
      hit[i] = ped_db[i] && !fault[i] && tick && (ms_cnt[i] == 16'(STUCK_MS - 1));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ms_cnt <= '0;
      fault  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!ped_db[i]) begin
          ms_cnt[i] <= '0;
          fault[i]  <= 1'b0;
        end else if (hit[i]) begin
          fault[i] <= 1'b1;
        end else if (tick && !fault[i]) begin
          ms_cnt[i] <= ms_cnt[i] + 16'd1;
        end
      end
    end
  end
`else
  assign fault = '0;
  assign hit   = '0;
`endif

  // request latch stage: a fresh press beats a coincident ACK
  always_ff @(posedge CLK) begin
    if (RST) begin
      ped_db_d <= '0;
      req      <= '0;
    end else begin
      ped_db_d <= ped_db;
      for (int i = 0; i < 3; i++) begin
        if (fault[i] || hit[i]) begin
          req[i] <= 1'b0;
        end else if (rise[i]) begin
          req[i] <= 1'b1;
        end else if (ack[i]) begin
          req[i] <= 1'b0;
        end
      end
    end
  end

  assign SNN_Q  = sens_db[CH_NN];
  assign SNS_Q  = sens_db[CH_NS];
  assign STH_Q  = sens_db[CH_TH];
  assign REQ_NN = req[CH_NN];
  assign REQ_NS = req[CH_NS];
  assign REQ_TH = req[CH_TH];
  assign FAULT  = fault;

endmodule
